sig_gen_sequencer: RTL
======================

SIG_GEN_SEQUENCER -- requirements
Module: sig_gen_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_ENTRIES, default 8, the number of program table entries (power of two, 2..8).
REQ-002 The block SHALL have parameter FREQ_W, default 16, the width of the frequency word driven to the signal generator.
REQ-003 The block SHALL have parameter DUR_W, default 16, the width of the per-entry duration counter.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, exactly as follows:
- wb_clk_i  in  1  system clock; all state SHALL be on the rising edge.
- wb_rst_ni  in  1  reset; asynchronous assertion, active-low.
REQ-005 The block SHALL have the following remaining ports:
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone cycle, strobe and write.
- wbs_sel_i  in  4  byte selects; ignored, all writes are full-word.
- wbs_adr_i  in  32  byte address; only bits [7:0] are decoded.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- wave_sel_o  out  2  waveform select to the signal generator.
- freq_word_o  out  FREQ_W  frequency/phase step to the signal generator.
- gen_en_o  out  1  signal generator enable.
- irq_o  out  1  sequence-done interrupt, level.

Function
REQ-006 The register map SHALL be:
- 0x00 CTRL RW: bit0 START (write-1 pulse, reads 0), bit1 STOP (write-1 pulse, reads 0), bit2 LOOP, bit3 IRQ_EN, bits[6:4] LAST_IDX.
- 0x04 STATUS: bits[1:0] FSM state, bit4 BUSY, bit8 DONE (sticky; write 1 clears).
- 0x08 IDX RO: current entry index.
- 0x40+8*i: entry i [17:16] wave, [FREQ_W-1:0] freq.
- 0x44+8*i: entry i [DUR_W-1:0] duration.
REQ-007 Unmapped addresses, and entries with i >= NUM_ENTRIES, SHALL read 0 and SHALL ignore writes.
REQ-008 wbs_ack_o SHALL assert for exactly one cycle, in the cycle after cyc&stb are first seen high with ack low; a write SHALL take effect on that ack edge; read data SHALL be valid while ack is high.
REQ-009 The FSM SHALL have states IDLE=0, LOAD=1, RUN=2; BUSY SHALL be 1 in LOAD and RUN.
REQ-010 In IDLE, START SHALL set idx=0, clear DONE and go to LOAD.
REQ-011 LOAD SHALL last one cycle; on exit it SHALL:
- copy entry[idx] wave and freq to wave_sel_o and freq_word_o;
- set gen_en_o=1;
- load the counter with max(duration,1);
- go to RUN.
REQ-012 RUN SHALL decrement the counter each cycle; entry outputs SHALL be held for exactly max(duration,1) cycles.
REQ-013 When the counter reaches 1 in RUN:
- if idx != LAST_IDX: idx+1, go to LOAD;
- else if LOOP=1: idx=0, go to LOAD;
- else: set DONE, gen_en_o=0, go to IDLE.
REQ-014 During LOAD cycles between entries, outputs SHALL keep the previous entry's values and gen_en_o SHALL stay 1.
REQ-015 LAST_IDX values >= NUM_ENTRIES SHALL be treated as NUM_ENTRIES-1.
REQ-016 STOP SHALL force IDLE from any state on its write edge, with gen_en_o=0 on the next cycle and DONE left unchanged.
REQ-017 START and STOP written together SHALL act as STOP; START while BUSY SHALL be ignored.
REQ-018 Table writes while BUSY SHALL be accepted and SHALL take effect the next time that entry is loaded.
REQ-019 irq_o SHALL equal DONE & IRQ_EN, registered.
REQ-020 The counter SHALL be DUR_W bits and SHALL never wrap.

Reset
REQ-021 Asynchronous assertion of wb_rst_ni=0 SHALL force the following, including mid-sequence; release SHALL be synchronised to wb_clk_i:
- state=IDLE, idx=0, counter=0;
- CTRL=0, DONE=0;
- all table entries=0;
- wbs_ack_o=0, wbs_dat_o=0, wave_sel_o=0, freq_word_o=0, gen_en_o=0, irq_o=0.

Verification
REQ-022 Program entry0 = (wave 1, freq 0x0100, dur 3) and entry1 = (wave 2, freq 0x0200, dur 2), LAST_IDX=1, IRQ_EN=1, then START -> expected:
- wave1/0x0100 for 3 cycles, 1 LOAD cycle, then wave2/0x0200 for 2 cycles;
- gen_en_o falls, DONE=1, irq_o=1;
- writing 1 to STATUS bit8 then drops irq_o.
REQ-023 Same program with LOOP=1 -> entries alternate indefinitely and IDX cycles 0,1,0; STOP then gives gen_en_o=0 next cycle and DONE=0.
REQ-024 Entry0 duration=0, LAST_IDX=0 -> outputs held for exactly 1 cycle, then DONE.
REQ-025 Boundary writes -> expected:
- START+STOP in one write: state stays IDLE;
- START while RUN: the sequence is unaffected;
- read of 0x3C and of 0x40+8*NUM_ENTRIES: returns 0.
REQ-026 Assert wb_rst_ni mid-RUN -> all outputs are 0 immediately (asynchronous); after release STATUS reads 0 and START works normally.

Source files
------------

// File: rtl/sig_gen_sequencer.sv
// Wishbone-programmable sequencer that steps a signal generator through a table of
// (waveform, frequency, duration) entries, optionally looping, with a done interrupt.
module sig_gen_sequencer #(
    parameter int NUM_ENTRIES = 8,
    parameter int FREQ_W      = 16,
    parameter int DUR_W       = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [1:0]        wave_sel_o,
    output logic [FREQ_W-1:0] freq_word_o,
    output logic              gen_en_o,
    output logic              irq_o
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    logic [1:0]        rst_sync_q;
    logic              rst_n;
    logic              ack_q;
    logic [31:0]       dat_q;
    logic              loop_q;
    logic              irq_en_q;
    logic [2:0]        last_idx_q;
    logic [1:0]        wave_tbl_q [NUM_ENTRIES];
    logic [FREQ_W-1:0] freq_tbl_q [NUM_ENTRIES];
    logic [DUR_W-1:0]  dur_tbl_q  [NUM_ENTRIES];
    state_e            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DUR_W-1:0]  cnt_q;
    logic              done_q;
    logic [1:0]        wave_q;
    logic [FREQ_W-1:0] freq_q;
    logic              gen_en_q;
    logic              irq_q;

    logic [5:0]        word_adr;
    logic [2:0]        ent_num;
    logic [IDX_W-1:0]  ent_idx;
    logic              ent_hit;
    logic              wb_access;
    logic              wr_en;
    logic              start_req;
    logic              stop_req;
    logic              done_clr;
    logic [IDX_W-1:0]  last_eff;
    logic [31:0]       rd_data;
    logic              unused_ok;

    // Reset asserts immediately but is released only after two clean clock edges.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) rst_sync_q <= 2'b00;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign word_adr  = wbs_adr_i[7:2];
    assign ent_num   = word_adr[3:1];
    assign ent_idx   = ent_num[IDX_W-1:0];
    assign ent_hit   = (word_adr[5:4] == 2'b01) && ({1'b0, ent_num} < 4'(NUM_ENTRIES));
    assign wb_access = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wr_en     = wb_access & wbs_we_i;
    assign stop_req  = wr_en && (word_adr == 6'h00) && wbs_dat_i[1];
    assign start_req = wr_en && (word_adr == 6'h00) && wbs_dat_i[0] && !wbs_dat_i[1];
    assign done_clr  = wr_en && (word_adr == 6'h01) && wbs_dat_i[8];
    assign last_eff  = ({1'b0, last_idx_q} >= 4'(NUM_ENTRIES)) ? IDX_W'(NUM_ENTRIES - 1)
                                                                 : last_idx_q[IDX_W-1:0];
    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[31:8], wbs_adr_i[1:0], wbs_dat_i};

    always_comb begin
        rd_data = '0;
        case (word_adr)
            6'h00: rd_data[6:2] = {last_idx_q, irq_en_q, loop_q};
            6'h01: begin
                rd_data[1:0] = state_q;
                rd_data[4]   = (state_q != IDLE);
                rd_data[8]   = done_q;
            end
            6'h02: rd_data[IDX_W-1:0] = idx_q;
            default: begin
                if (ent_hit && !word_adr[0]) begin
                    rd_data[17:16]       = wave_tbl_q[ent_idx];
                    rd_data[FREQ_W-1:0]  = freq_tbl_q[ent_idx];
                end else if (ent_hit) begin
                    rd_data[DUR_W-1:0]   = dur_tbl_q[ent_idx];
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            loop_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            last_idx_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                wave_tbl_q[i] <= '0;
                freq_tbl_q[i] <= '0;
                dur_tbl_q[i]  <= '0;
            end
        end else begin
            ack_q <= wb_access;
            dat_q <= wb_access ? rd_data : '0;
            if (wr_en && word_adr == 6'h00) begin
                loop_q     <= wbs_dat_i[2];
                irq_en_q   <= wbs_dat_i[3];
                last_idx_q <= wbs_dat_i[6:4];
            end
            if (wr_en && ent_hit && !word_adr[0]) begin
                wave_tbl_q[ent_idx] <= wbs_dat_i[17:16];
                freq_tbl_q[ent_idx] <= wbs_dat_i[FREQ_W-1:0];
            end
            if (wr_en && ent_hit && word_adr[0]) begin
                dur_tbl_q[ent_idx] <= wbs_dat_i[DUR_W-1:0];
            end
        end
    end

    // Sequencer FSM; STOP overrides everything, and a DONE set wins over a same-cycle clear.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            wave_q   <= '0;
            freq_q   <= '0;
            gen_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_q <= done_q & irq_en_q;
            if (done_clr) done_q <= 1'b0;
            if (stop_req) begin
                state_q  <= IDLE;
                gen_en_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_req) begin
                            idx_q   <= '0;
                            done_q  <= 1'b0;
                            state_q <= LOAD;
                        end
                    end
                    LOAD: begin
                        wave_q   <= wave_tbl_q[idx_q];
                        freq_q   <= freq_tbl_q[idx_q];
                        gen_en_q <= 1'b1;
                        cnt_q    <= (dur_tbl_q[idx_q] == '0) ? DUR_W'(1) : dur_tbl_q[idx_q];
                        state_q  <= RUN;
                    end
                    RUN: begin
                        if (cnt_q <= DUR_W'(1)) begin
                            cnt_q <= '0;
                            if (idx_q != last_eff) begin
                                idx_q   <= idx_q + IDX_W'(1);
                                state_q <= LOAD;
                            end else if (loop_q) begin
                                idx_q   <= '0;
                                state_q <= LOAD;
                            end else begin
                                done_q   <= 1'b1;
                                gen_en_q <= 1'b0;
                                state_q  <= IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q - DUR_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign wave_sel_o  = wave_q;
    assign freq_word_o = freq_q;
    assign gen_en_o    = gen_en_q;
    assign irq_o       = irq_q;

endmodule
